// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults, typedefs and constants for the regfile_sb slice
package regfile_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = $clog2(NREGS);

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   xword_t;

  // Architectural zero register: reads 0, never busy, ignores writes/claims
  localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - pending-write busy bits for each architectural register
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = regfile_pkg::NREGS,
  parameter int NWR   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NWR-1:0]          wr_en,
  input  logic [NWR-1:0][AW-1:0]  wr_addr,
  input  logic                    claim_en,
  input  logic [AW-1:0]           claim_addr,
  output logic [NREGS-1:0]        busy
);

  localparam logic [AW-1:0] ZERO_A = AW'(ZERO_REG);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Writes retire pending entries first; a same-cycle claim then re-marks the register
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NWR; i++) begin
      if (wr_en[i] && (wr_addr[i] != ZERO_A)) begin
        busy_d[wr_addr[i]] = 1'b0;
      end
    end
    if (claim_en && (claim_addr != ZERO_A)) begin
      busy_d[claim_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Busy register; reset drops every pending claim immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-port register file with scoreboard; optional REGFILE_SB_BYPASS_EN forwarding
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN  = regfile_pkg::XLEN,
  parameter int NREGS = regfile_pkg::NREGS,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NRD-1:0][AW-1:0]   rd_addr,
  output logic [NRD-1:0][XLEN-1:0] rd_data,
  output logic [NRD-1:0]           rd_busy,
  input  logic [NWR-1:0]           wr_en,
  input  logic [NWR-1:0][AW-1:0]   wr_addr,
  input  logic [NWR-1:0][XLEN-1:0] wr_data,
  input  logic                     claim_en,
  input  logic [AW-1:0]            claim_addr
);

  localparam logic [AW-1:0] ZERO_A = AW'(ZERO_REG);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy;

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .busy       (busy)
  );

  // Next register state; ascending port order lets the highest-index writer win
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NWR; i++) begin
      if (wr_en[i] && (wr_addr[i] != ZERO_A)) begin
        regs_d[wr_addr[i]] = wr_data[i];
      end
    end
    regs_d[0] = '0;
  end

  // Register storage with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Zero-latency read ports; x0 is forced to zero and never busy
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NRD; p++) begin
      if (rd_addr[p] != ZERO_A) begin
        rd_data[p] = regs_q[rd_addr[p]];
        rd_busy[p] = busy[rd_addr[p]];
`ifdef REGFILE_SB_BYPASS_EN
        // Forward in-flight writes (highest port wins); a same-cycle claim keeps it busy
        if (!rst) begin
          for (int i = 0; i < NWR; i++) begin
            if (wr_en[i] && (wr_addr[i] == rd_addr[p])) begin
              rd_data[p] = wr_data[i];
              rd_busy[p] = claim_en && (claim_addr == rd_addr[p]);
            end
          end
        end
`endif
      end
    end
  end

endmodule
